rs_bank: RTL and testbench

- Bank of N+1 reservation-station entries for one functional unit in the Tomasulo LC-3b core.
- Sits directly downstream of the per-station load-enable decode. It consumes the per-entry issue load strobes plus the shared issue operand bus.
- Entries snoop the CDB for outstanding tags and dispatch one ready entry per handshake to the functional unit.

---
 rtl/rs_bank.sv | 186 ++++++++++++++++++
 tb/tb_rs_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_bank.sv
// Reservation-station bank: issue writes, CDB snoop with issue-cycle bypass,
// lowest-index dispatch through a registered FU slot that holds while the FU stalls.
module rs_bank #(
  parameter int n     = 2,
  parameter int TAG_W = 3,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [n:0]       RS_ld_busy,
  input  logic [n:0]       RS_issue_ld_Vj,
  input  logic [n:0]       RS_issue_ld_Vk,
  input  logic [n:0]       RS_issue_ld_Qj,
  input  logic [n:0]       RS_issue_ld_Qk,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [TAG_W-1:0] issue_dest,
  input  logic [15:0]      issue_Vj,
  input  logic [15:0]      issue_Vk,
  input  logic [TAG_W-1:0] issue_Qj,
  input  logic [TAG_W-1:0] issue_Qk,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [15:0]      cdb_data,
  output logic             fu_valid,
  input  logic             fu_ready,
  output logic [OP_W-1:0]  fu_op,
  output logic [15:0]      fu_Vj,
  output logic [15:0]      fu_Vk,
  output logic [TAG_W-1:0] fu_dest,
  output logic [n:0]       busy,
  output logic             rs_full
);

  logic [n:0]       busy_q, busy_d, qj_pend_q, qj_pend_d, qk_pend_q, qk_pend_d;
  logic [OP_W-1:0]  op_q [0:n];
  logic [OP_W-1:0]  op_d [0:n];
  logic [TAG_W-1:0] dest_q [0:n];
  logic [TAG_W-1:0] dest_d [0:n];
  logic [TAG_W-1:0] qj_q [0:n];
  logic [TAG_W-1:0] qj_d [0:n];
  logic [TAG_W-1:0] qk_q [0:n];
  logic [TAG_W-1:0] qk_d [0:n];
  logic [15:0]      vj_q [0:n];
  logic [15:0]      vj_d [0:n];
  logic [15:0]      vk_q [0:n];
  logic [15:0]      vk_d [0:n];

  logic             fu_valid_q, fu_valid_d;
  logic [OP_W-1:0]  fu_op_q, fu_op_d;
  logic [15:0]      fu_vj_q, fu_vj_d, fu_vk_q, fu_vk_d;
  logic [TAG_W-1:0] fu_dest_q, fu_dest_d;

  logic [n:0] ready, grant, freed;
  logic       slot_open;

  always_comb begin
    ready     = busy_q & ~qj_pend_q & ~qk_pend_q;
    grant     = ready & (~ready + {{n{1'b0}}, 1'b1});
    slot_open = !fu_valid_q || fu_ready;
    freed     = slot_open ? grant : '0;

    busy_d    = busy_q;
    qj_pend_d = qj_pend_q;
    qk_pend_d = qk_pend_q;
    op_d      = op_q;
    dest_d    = dest_q;
    qj_d      = qj_q;
    qk_d      = qk_q;
    vj_d      = vj_q;
    vk_d      = vk_q;

    fu_valid_d = fu_valid_q;
    fu_op_d    = fu_op_q;
    fu_vj_d    = fu_vj_q;
    fu_vk_d    = fu_vk_q;
    fu_dest_d  = fu_dest_q;

    if (slot_open) begin
      fu_valid_d = |ready;
      for (int i = 0; i <= n; i++) begin
        if (grant[i]) begin
          fu_op_d   = op_q[i];
          fu_vj_d   = vj_q[i];
          fu_vk_d   = vk_q[i];
          fu_dest_d = dest_q[i];
        end
      end
    end

    for (int i = 0; i <= n; i++) begin
      if (cdb_valid && busy_q[i] && qj_pend_q[i] && qj_q[i] == cdb_tag) begin
        vj_d[i]      = cdb_data;
        qj_pend_d[i] = 1'b0;
      end
      if (cdb_valid && busy_q[i] && qk_pend_q[i] && qk_q[i] == cdb_tag) begin
        vk_d[i]      = cdb_data;
        qk_pend_d[i] = 1'b0;
      end
      if (freed[i]) busy_d[i] = 1'b0;

      // A slot being dispatched this edge may be refilled on the same edge.
      if (RS_ld_busy[i] && (!busy_q[i] || freed[i])) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        dest_d[i] = issue_dest;
        if (RS_issue_ld_Qj[i]) begin
          if (cdb_valid && issue_Qj == cdb_tag) begin
            vj_d[i]      = cdb_data;
            qj_pend_d[i] = 1'b0;
          end else begin
            qj_d[i]      = issue_Qj;
            qj_pend_d[i] = 1'b1;
          end
        end else if (RS_issue_ld_Vj[i]) begin
          vj_d[i]      = issue_Vj;
          qj_pend_d[i] = 1'b0;
        end
        if (RS_issue_ld_Qk[i]) begin
          if (cdb_valid && issue_Qk == cdb_tag) begin
            vk_d[i]      = cdb_data;
            qk_pend_d[i] = 1'b0;
          end else begin
            qk_d[i]      = issue_Qk;
            qk_pend_d[i] = 1'b1;
          end
        end else if (RS_issue_ld_Vk[i]) begin
          vk_d[i]      = issue_Vk;
          qk_pend_d[i] = 1'b0;
        end
      end
    end

    if (flush) begin
      busy_d     = '0;
      qj_pend_d  = '0;
      qk_pend_d  = '0;
      fu_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      qj_pend_q  <= '0;
      qk_pend_q  <= '0;
      fu_valid_q <= 1'b0;
      fu_op_q    <= '0;
      fu_vj_q    <= '0;
      fu_vk_q    <= '0;
      fu_dest_q  <= '0;
      for (int i = 0; i <= n; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      qj_pend_q  <= qj_pend_d;
      qk_pend_q  <= qk_pend_d;
      fu_valid_q <= fu_valid_d;
      fu_op_q    <= fu_op_d;
      fu_vj_q    <= fu_vj_d;
      fu_vk_q    <= fu_vk_d;
      fu_dest_q  <= fu_dest_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
    end
  end

  assign fu_valid = fu_valid_q;
  assign fu_op    = fu_op_q;
  assign fu_Vj    = fu_vj_q;
  assign fu_Vk    = fu_vk_q;
  assign fu_dest  = fu_dest_q;
  assign busy     = busy_q;
  assign rs_full  = &busy_q;

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank with a dispatch scoreboard checked at each FU handshake.
module tb_rs_bank;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  dest;
    logic [15:0] vj;
    logic [15:0] vk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  RS_ld_busy, RS_issue_ld_Vj, RS_issue_ld_Vk, RS_issue_ld_Qj, RS_issue_ld_Qk;
  logic [3:0]  issue_op;
  logic [2:0]  issue_dest, issue_Qj, issue_Qk;
  logic [15:0] issue_Vj, issue_Vk;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        fu_valid, fu_ready;
  logic [3:0]  fu_op;
  logic [15:0] fu_Vj, fu_Vk;
  logic [2:0]  fu_dest;
  logic [2:0]  busy;
  logic        rs_full;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  rs_bank #(.n(2), .TAG_W(3), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .RS_ld_busy(RS_ld_busy), .RS_issue_ld_Vj(RS_issue_ld_Vj), .RS_issue_ld_Vk(RS_issue_ld_Vk),
    .RS_issue_ld_Qj(RS_issue_ld_Qj), .RS_issue_ld_Qk(RS_issue_ld_Qk),
    .issue_op(issue_op), .issue_dest(issue_dest), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_op(fu_op), .fu_Vj(fu_Vj), .fu_Vk(fu_Vk),
    .fu_dest(fu_dest), .busy(busy), .rs_full(rs_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [3:0] op, input logic [2:0] dest,
                       input logic ldvj, input logic [15:0] vj,
                       input logic ldvk, input logic [15:0] vk,
                       input logic ldqj, input logic [2:0] qj,
                       input logic ldqk, input logic [2:0] qk);
    RS_ld_busy          = '0;
    RS_issue_ld_Vj      = '0;
    RS_issue_ld_Vk      = '0;
    RS_issue_ld_Qj      = '0;
    RS_issue_ld_Qk      = '0;
    RS_ld_busy[idx]     = 1'b1;
    RS_issue_ld_Vj[idx] = ldvj;
    RS_issue_ld_Vk[idx] = ldvk;
    RS_issue_ld_Qj[idx] = ldqj;
    RS_issue_ld_Qk[idx] = ldqk;
    issue_op   = op;
    issue_dest = dest;
    issue_Vj   = vj;
    issue_Vk   = vk;
    issue_Qj   = qj;
    issue_Qk   = qk;
    tick();
    RS_ld_busy     = '0;
    RS_issue_ld_Vj = '0;
    RS_issue_ld_Vk = '0;
    RS_issue_ld_Qj = '0;
    RS_issue_ld_Qk = '0;
  endtask

  task automatic wait_drain(input int budget);
    int cyc = 0;
    while (sb.size() != 0 && cyc < budget) begin
      tick();
      cyc++;
    end
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard: every accepted dispatch must match the oldest expected entry.
  always @(negedge clk) begin
    total++;
    assert ($onehot0(RS_ld_busy)) else begin
      bad++;
      $error("FAIL ld_busy_onehot: got %b want at most one bit", RS_ld_busy);
    end
    if (rst_n && fu_valid && fu_ready) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_dispatch: got op=%0h dest=%0h want none", fu_op, fu_dest);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("fu_op", 32'(fu_op), 32'(e.op));
        chk("fu_dest", 32'(fu_dest), 32'(e.dest));
        chk("fu_Vj", 32'(fu_Vj), 32'(e.vj));
        chk("fu_Vk", 32'(fu_Vk), 32'(e.vk));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; fu_ready = 1'b1;
    RS_ld_busy = '0; RS_issue_ld_Vj = '0; RS_issue_ld_Vk = '0;
    RS_issue_ld_Qj = '0; RS_issue_ld_Qk = '0;
    issue_op = '0; issue_dest = '0; issue_Vj = '0; issue_Vk = '0; issue_Qj = '0; issue_Qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

    #2;
    chk("rst_fu_valid", 32'(fu_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_fu_op", 32'(fu_op), 0);
    chk("rst_fu_Vj", 32'(fu_Vj), 0);
    chk("rst_fu_Vk", 32'(fu_Vk), 0);
    chk("rst_fu_dest", 32'(fu_dest), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Simple ready issue on entry 1.
    sb.push_back('{op: 4'h1, dest: 3'd2, vj: 16'h0005, vk: 16'h0003});
    issue(1, 4'h1, 3'd2, 1'b1, 16'h0005, 1'b1, 16'h0003, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("t1_busy_after_issue", 32'(busy), 32'b010);
    chk("t1_no_valid_yet", 32'(fu_valid), 0);
    tick();
    chk("t1_valid", 32'(fu_valid), 1);
    chk("t1_vj", 32'(fu_Vj), 32'h5);
    chk("t1_dest", 32'(fu_dest), 2);
    tick();
    chk("t1_busy_after_hs", 32'(busy), 0);
    chk("t1_valid_drop", 32'(fu_valid), 0);
    wait_drain(2);

    // Pending Qj woken by CDB.
    issue(0, 4'h2, 3'd5, 1'b0, 16'h0, 1'b1, 16'h0010, 1'b1, 3'd4, 1'b0, 3'd0);
    chk("t2_busy", 32'(busy), 32'b001);
    tick(); tick();
    chk("t2_no_dispatch", 32'(fu_valid), 0);
    sb.push_back('{op: 4'h2, dest: 3'd5, vj: 16'h1234, vk: 16'h0010});
    cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'h1234;
    tick();
    cdb_valid = 1'b0;
    chk("t2_capture_cycle", 32'(fu_valid), 0);
    tick();
    chk("t2_valid", 32'(fu_valid), 1);
    chk("t2_vj", 32'(fu_Vj), 32'h1234);
    wait_drain(4);

    // Issue/CDB same-cycle bypass on k.
    sb.push_back('{op: 4'h3, dest: 3'd6, vj: 16'h0007, vk: 16'hBEEF});
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 16'hBEEF;
    issue(2, 4'h3, 3'd6, 1'b1, 16'h0007, 1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd3);
    cdb_valid = 1'b0;
    tick();
    chk("t3_valid", 32'(fu_valid), 1);
    chk("t3_vk", 32'(fu_Vk), 32'hBEEF);
    wait_drain(4);
    tick();

    // Fill the bank behind a stalled slot, including same-edge refill of entry 0.
    fu_ready = 1'b0;
    sb.push_back('{op: 4'h4, dest: 3'd1, vj: 16'h0011, vk: 16'h0021});
    issue(0, 4'h4, 3'd1, 1'b1, 16'h0011, 1'b1, 16'h0021, 1'b0, 3'd0, 1'b0, 3'd0);
    sb.push_back('{op: 4'h4, dest: 3'd2, vj: 16'h0012, vk: 16'h0022});
    issue(0, 4'h4, 3'd2, 1'b1, 16'h0012, 1'b1, 16'h0022, 1'b0, 3'd0, 1'b0, 3'd0);
    sb.push_back('{op: 4'h4, dest: 3'd3, vj: 16'h0013, vk: 16'h0023});
    issue(1, 4'h4, 3'd3, 1'b1, 16'h0013, 1'b1, 16'h0023, 1'b0, 3'd0, 1'b0, 3'd0);
    sb.push_back('{op: 4'h4, dest: 3'd4, vj: 16'h0014, vk: 16'h0024});
    issue(2, 4'h4, 3'd4, 1'b1, 16'h0014, 1'b1, 16'h0024, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("t4_busy_all", 32'(busy), 32'b111);
    chk("t4_full", 32'(rs_full), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_hold_valid", 32'(fu_valid), 1);
      chk("t4_hold_vj", 32'(fu_Vj), 32'h11);
      chk("t4_hold_dest", 32'(fu_dest), 1);
    end
    fu_ready = 1'b1;
    tick();
    chk("t4_full_drop", 32'(rs_full), 0);
    chk("t4_next_slot", 32'(fu_Vj), 32'h12);
    wait_drain(8);
    tick();
    chk("t4_idle", 32'(fu_valid), 0);

    // Issue to a busy entry is ignored.
    issue(1, 4'h5, 3'd3, 1'b0, 16'h0, 1'b1, 16'h0066, 1'b1, 3'd7, 1'b0, 3'd0);
    issue(1, 4'h9, 3'd7, 1'b1, 16'hAAAA, 1'b1, 16'hBBBB, 1'b0, 3'd0, 1'b0, 3'd0);
    chk("t5_busy", 32'(busy), 32'b010);
    chk("t5_no_dispatch", 32'(fu_valid), 0);
    sb.push_back('{op: 4'h5, dest: 3'd3, vj: 16'h0055, vk: 16'h0066});
    cdb_valid = 1'b1; cdb_tag = 3'd7; cdb_data = 16'h0055;
    tick();
    cdb_valid = 1'b0;
    wait_drain(4);
    tick();
    chk("t5_idle_busy", 32'(busy), 0);

    // Flush beats a same-cycle CDB wakeup.
    issue(0, 4'h1, 3'd1, 1'b0, 16'h0, 1'b1, 16'h0001, 1'b1, 3'd1, 1'b0, 3'd0);
    issue(1, 4'h1, 3'd2, 1'b1, 16'h0002, 1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 3'd2);
    chk("t6_busy_pending", 32'(busy), 32'b011);
    flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 16'h0077;
    tick();
    flush = 1'b0; cdb_valid = 1'b0;
    chk("t6_flush_busy", 32'(busy), 0);
    chk("t6_flush_valid", 32'(fu_valid), 0);
    cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 16'h0088;
    tick();
    cdb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_no_dispatch", 32'(fu_valid), 0);
    end

    // Async reset while the slot is stalled.
    fu_ready = 1'b0;
    issue(2, 4'h6, 3'd4, 1'b1, 16'h0099, 1'b1, 16'h0098, 1'b0, 3'd0, 1'b0, 3'd0);
    tick();
    chk("t7_valid_before_rst", 32'(fu_valid), 1);
    chk("t7_op_before_rst", 32'(fu_op), 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_valid", 32'(fu_valid), 0);
    chk("t7_rst_op", 32'(fu_op), 0);
    chk("t7_rst_vj", 32'(fu_Vj), 0);
    chk("t7_rst_vk", 32'(fu_Vk), 0);
    chk("t7_rst_dest", 32'(fu_dest), 0);
    chk("t7_rst_busy", 32'(busy), 0);
    chk("t7_rst_full", 32'(rs_full), 0);
    tick();
    rst_n = 1'b1;
    fu_ready = 1'b1;
    tick(); tick();
    chk("t7_after_rst_idle", 32'(fu_valid), 0);
    chk("sb_empty_at_end", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
